// File: rtl/bp_mem_cmd_router.sv
`default_nettype none
// ============================================================================
//  Module      : bp_mem_cmd_router
//  Description : Steers CCE memory commands to host MMIO or DRAM by address,
//                returns responses in issue order, flags a stalled head.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_mem_cmd_router #(
    parameter int                      msg_width_p       = 128,
    parameter int                      addr_width_p      = 39,
    parameter logic [addr_width_p-1:0] dram_base_p       = 39'h00_4000_0000,
    parameter int                      max_outstanding_p = 4,
    parameter int                      timeout_cycles_p  = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [msg_width_p-1:0]                 mem_cmd_i,
    input  logic [addr_width_p-1:0]                mem_cmd_addr_i,
    input  logic                                   mem_cmd_v_i,
    output logic                                   mem_cmd_yumi_o,

    output logic [msg_width_p-1:0]                 host_cmd_o,
    output logic                                   host_cmd_v_o,
    input  logic                                   host_cmd_yumi_i,
    output logic [msg_width_p-1:0]                 dram_cmd_o,
    output logic                                   dram_cmd_v_o,
    input  logic                                   dram_cmd_yumi_i,

    input  logic [msg_width_p-1:0]                 host_resp_i,
    input  logic                                   host_resp_v_i,
    output logic                                   host_resp_yumi_o,
    input  logic [msg_width_p-1:0]                 dram_resp_i,
    input  logic                                   dram_resp_v_i,
    output logic                                   dram_resp_yumi_o,

    output logic [msg_width_p-1:0]                 mem_resp_o,
    output logic                                   mem_resp_v_o,
    input  logic                                   mem_resp_ready_i,

    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   timeout_o
);

    localparam int c_cnt_w  = $clog2(max_outstanding_p + 1);
    localparam int c_wdog_w = $clog2(timeout_cycles_p + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max  = c_cnt_w'(max_outstanding_p);
    localparam logic [c_wdog_w-1:0] c_wdog_max = c_wdog_w'(timeout_cycles_p);
    localparam logic [c_wdog_w-1:0] c_wdog_hit = c_wdog_w'(timeout_cycles_p - 1);

    // Order FIFO as a shift register: bit 0 is the head, 1 = DRAM, 0 = host.
    logic [max_outstanding_p-1:0] r_order;
    logic [max_outstanding_p-1:0] w_order_nxt;
    logic [c_cnt_w-1:0]           r_count;
    logic [c_cnt_w-1:0]           w_count_nxt;
    logic [c_cnt_w-1:0]           w_wr_idx;
    logic [c_wdog_w-1:0]          r_wdog;
    logic                         r_timeout;

    logic w_sel_dram;
    logic w_room;
    logic w_push;
    logic w_empty;
    logic w_head_dram;
    logic w_head_v;
    logic w_pop;
    logic w_wdog_inc;

    assign w_sel_dram = (mem_cmd_addr_i >= dram_base_p);
    assign w_room     = (r_count < c_cnt_max);

    assign host_cmd_o   = mem_cmd_i;
    assign dram_cmd_o   = mem_cmd_i;
    assign host_cmd_v_o = ~reset_i & mem_cmd_v_i & ~w_sel_dram & w_room;
    assign dram_cmd_v_o = ~reset_i & mem_cmd_v_i &  w_sel_dram & w_room;

    assign w_push         = w_sel_dram ? (dram_cmd_v_o & dram_cmd_yumi_i)
                                       : (host_cmd_v_o & host_cmd_yumi_i);
    assign mem_cmd_yumi_o = w_push;

    // Only the head target may return; the other target's response waits.
    assign w_empty     = (r_count == '0);
    assign w_head_dram = r_order[0];
    assign w_head_v    = ~reset_i & ~w_empty & (w_head_dram ? dram_resp_v_i : host_resp_v_i);
    assign w_pop       = w_head_v & mem_resp_ready_i;

    assign mem_resp_v_o     = w_head_v;
    assign mem_resp_o       = w_head_dram ? dram_resp_i : host_resp_i;
    assign host_resp_yumi_o = w_pop & ~w_head_dram;
    assign dram_resp_yumi_o = w_pop &  w_head_dram;

    assign outstanding_o = r_count;
    assign timeout_o     = r_timeout;
    assign w_wdog_inc    = ~w_empty & ~w_pop;

    always_comb begin
        w_order_nxt = r_order;
        w_wr_idx    = r_count;
        if (w_pop) begin
            w_order_nxt = r_order >> 1;
            w_wr_idx    = r_count - c_cnt_w'(1);
        end
        if (w_push) begin
            for (int i = 0; i < max_outstanding_p; i++) begin
                if (w_wr_idx == c_cnt_w'(i)) begin
                    w_order_nxt[i] = w_sel_dram;
                end
            end
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_order   <= '0;
            r_count   <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_order <= w_order_nxt;
            r_count <= w_count_nxt;
            if (!w_wdog_inc) begin
                r_wdog <= '0;
            end else if (r_wdog != c_wdog_max) begin
                r_wdog <= r_wdog + c_wdog_w'(1);
            end
            if (w_wdog_inc && (r_wdog == c_wdog_hit)) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_mem_cmd_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_mem_cmd_router
//  Description : Randomized bench for bp_mem_cmd_router with an in-order
//                queue reference model and simple target models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_mem_cmd_router;

    localparam int          MW   = 128;
    localparam int          AW   = 39;
    localparam int          MAX  = 4;
    localparam int          TMO  = 16;
    localparam logic [AW-1:0] BASE = 39'h00_4000_0000;
    localparam logic [MW-1:0] MASK = {4{32'hA5A5_5A5A}};

    logic          clk = 1'b0;
    logic          reset_i;
    logic [MW-1:0] mem_cmd_i;
    logic [AW-1:0] mem_cmd_addr_i;
    logic          mem_cmd_v_i;
    logic          mem_cmd_yumi_o;
    logic [MW-1:0] host_cmd_o;
    logic          host_cmd_v_o;
    logic          host_cmd_yumi_i;
    logic [MW-1:0] dram_cmd_o;
    logic          dram_cmd_v_o;
    logic          dram_cmd_yumi_i;
    logic [MW-1:0] host_resp_i;
    logic          host_resp_v_i;
    logic          host_resp_yumi_o;
    logic [MW-1:0] dram_resp_i;
    logic          dram_resp_v_i;
    logic          dram_resp_yumi_o;
    logic [MW-1:0] mem_resp_o;
    logic          mem_resp_v_o;
    logic          mem_resp_ready_i;
    logic [2:0]    outstanding_o;
    logic          timeout_o;

    bp_mem_cmd_router #(
        .msg_width_p      (MW),
        .addr_width_p     (AW),
        .dram_base_p      (BASE),
        .max_outstanding_p(MAX),
        .timeout_cycles_p (TMO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_addr_i  (mem_cmd_addr_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_yumi_o  (mem_cmd_yumi_o),
        .host_cmd_o      (host_cmd_o),
        .host_cmd_v_o    (host_cmd_v_o),
        .host_cmd_yumi_i (host_cmd_yumi_i),
        .dram_cmd_o      (dram_cmd_o),
        .dram_cmd_v_o    (dram_cmd_v_o),
        .dram_cmd_yumi_i (dram_cmd_yumi_i),
        .host_resp_i     (host_resp_i),
        .host_resp_v_i   (host_resp_v_i),
        .host_resp_yumi_o(host_resp_yumi_o),
        .dram_resp_i     (dram_resp_i),
        .dram_resp_v_i   (dram_resp_v_i),
        .dram_resp_yumi_o(dram_resp_yumi_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_ready_i(mem_resp_ready_i),
        .outstanding_o   (outstanding_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: issue-order queue plus per-target pending commands.
    logic [MW-1:0] host_pend[$];
    logic [MW-1:0] dram_pend[$];
    logic [MW-1:0] ref_data[$];
    bit            ref_tgt[$];
    int            wait_cnt = 0;
    bit            tmo      = 1'b0;

    task automatic check_eq(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom % 6)
            0, 1:    return AW'($urandom_range(0, 32'h3FFF_FFFF));
            2, 3:    return BASE + AW'($urandom);
            4:       return BASE - AW'(1);
            default: return BASE;
        endcase
    endfunction

    task automatic model_clear();
        host_pend.delete();
        dram_pend.delete();
        ref_data.delete();
        ref_tgt.delete();
        wait_cnt = 0;
        tmo      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i          = 1'b1;
        mem_cmd_v_i      = 1'b1;
        mem_cmd_addr_i   = BASE;
        host_cmd_yumi_i  = 1'b1;
        dram_cmd_yumi_i  = 1'b1;
        host_resp_v_i    = 1'b1;
        dram_resp_v_i    = 1'b1;
        mem_resp_ready_i = 1'b1;
        #1;
        check_eq("rst_outstanding", MW'(outstanding_o), '0);
        check_eq("rst_timeout", MW'(timeout_o), '0);
        check_eq("rst_host_cmd_v", MW'(host_cmd_v_o), '0);
        check_eq("rst_dram_cmd_v", MW'(dram_cmd_v_o), '0);
        check_eq("rst_cmd_yumi", MW'(mem_cmd_yumi_o), '0);
        check_eq("rst_resp_v", MW'(mem_resp_v_o), '0);
        check_eq("rst_host_resp_yumi", MW'(host_resp_yumi_o), '0);
        check_eq("rst_dram_resp_yumi", MW'(dram_resp_yumi_o), '0);
        model_clear();
        @(negedge clk);
        reset_i          = 1'b0;
        mem_cmd_v_i      = 1'b0;
        host_cmd_yumi_i  = 1'b0;
        dram_cmd_yumi_i  = 1'b0;
        host_resp_v_i    = 1'b0;
        dram_resp_v_i    = 1'b0;
        mem_resp_ready_i = 1'b0;
    endtask

    // One clock: drive stimulus, check against model, advance model over the edge.
    task automatic cycle(input bit v, input logic [AW-1:0] addr, input bit h_ok, input bit d_ok,
                         input bit hr_ok, input bit dr_ok, input bit rdy, input bit spur);
        bit            sel_d, room, e_hv, e_dv, head_d, e_rv, e_pop;
        logic [MW-1:0] cmd;
        int            sz;
        @(negedge clk);
        cmd            = rand128();
        mem_cmd_v_i    = v;
        mem_cmd_addr_i = addr;
        mem_cmd_i      = cmd;
        sz    = ref_tgt.size();
        sel_d = (addr >= BASE);
        room  = (sz < MAX);
        e_hv  = v && !sel_d && room;
        e_dv  = v &&  sel_d && room;
        host_cmd_yumi_i = e_hv && h_ok;
        dram_cmd_yumi_i = e_dv && d_ok;
        if (host_pend.size() > 0) begin
            host_resp_v_i = hr_ok;
            host_resp_i   = host_pend[0] ^ MASK;
        end else begin
            host_resp_v_i = spur;
            host_resp_i   = rand128();
        end
        if (dram_pend.size() > 0) begin
            dram_resp_v_i = dr_ok;
            dram_resp_i   = dram_pend[0] ^ MASK;
        end else begin
            dram_resp_v_i = spur;
            dram_resp_i   = rand128();
        end
        mem_resp_ready_i = rdy;
        head_d = (sz > 0) ? ref_tgt[0] : 1'b0;
        e_rv   = (sz > 0) && (head_d ? dram_resp_v_i : host_resp_v_i);
        e_pop  = e_rv && rdy;
        #1;
        check_eq("outstanding", MW'(outstanding_o), MW'(sz));
        check_eq("host_cmd_v", MW'(host_cmd_v_o), MW'(e_hv));
        check_eq("dram_cmd_v", MW'(dram_cmd_v_o), MW'(e_dv));
        check_eq("host_cmd_data", host_cmd_o, cmd);
        check_eq("dram_cmd_data", dram_cmd_o, cmd);
        check_eq("cmd_yumi", MW'(mem_cmd_yumi_o), MW'(host_cmd_yumi_i | dram_cmd_yumi_i));
        check_eq("resp_v", MW'(mem_resp_v_o), MW'(e_rv));
        if (e_rv) check_eq("resp_data", mem_resp_o, ref_data[0]);
        check_eq("host_resp_yumi", MW'(host_resp_yumi_o), MW'(e_pop && !head_d));
        check_eq("dram_resp_yumi", MW'(dram_resp_yumi_o), MW'(e_pop && head_d));
        check_eq("timeout", MW'(timeout_o), MW'(tmo));
        if (e_pop) begin
            if (head_d) void'(dram_pend.pop_front());
            else        void'(host_pend.pop_front());
            void'(ref_tgt.pop_front());
            void'(ref_data.pop_front());
        end
        if (host_cmd_yumi_i) begin
            host_pend.push_back(cmd);
            ref_tgt.push_back(1'b0);
            ref_data.push_back(cmd ^ MASK);
        end
        if (dram_cmd_yumi_i) begin
            dram_pend.push_back(cmd);
            ref_tgt.push_back(1'b1);
            ref_data.push_back(cmd ^ MASK);
        end
        if (sz > 0 && !e_pop) begin
            if (wait_cnt < TMO) wait_cnt++;
            if (wait_cnt == TMO) tmo = 1'b1;
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic idle(input int n, input bit hr_ok, input bit dr_ok, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, hr_ok, dr_ok, rdy, 1'b0);
    endtask

    initial begin
        reset_i          = 1'b1;
        mem_cmd_i        = '0;
        mem_cmd_addr_i   = '0;
        mem_cmd_v_i      = 1'b0;
        host_cmd_yumi_i  = 1'b0;
        dram_cmd_yumi_i  = 1'b0;
        host_resp_i      = '0;
        host_resp_v_i    = 1'b0;
        dram_resp_i      = '0;
        dram_resp_v_i    = 1'b0;
        mem_resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Host command accepted in the same cycle, then returned.
        cycle(1'b1, 39'h0_0010_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1, 1'b1);

        // Address boundary on either side of the DRAM base.
        cycle(1'b1, BASE - AW'(1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, BASE,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b1, 1'b1);

        // Fill to max outstanding; fifth command must be held off.
        for (int i = 0; i < 5; i++) cycle(1'b1, 39'h7F_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 39'h0_0000_1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 39'h0_0000_2000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 39'h7F_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(10, 1'b1, 1'b1, 1'b1);

        // Host then DRAM; DRAM answers first and must wait for the host.
        cycle(1'b1, 39'h0_0020_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 39'h40_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1, 1'b1);

        // Stray responses with nothing outstanding are ignored.
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Watchdog: unanswered head, then a late response.
        cycle(1'b1, 39'h0_0030_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(TMO + 3, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of traffic.
        cycle(1'b1, 39'h0_0040_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 39'h50_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, rand_addr(), $urandom % 2, $urandom % 2,
                  ($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
